// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Sits directly upstream of program memory and drives its load port. It takes
// a byte stream over a valid/ready handshake and assembles 14-bit instructions
// from HI/LO byte pairs. Each instruction is written to the next sequential
// program-memory address, starting at 0. The stream is checked against a
// header word count and a trailing 8-bit checksum. o_busy holds the CPU while
// a load is in progress.
//
// Stream layout: H, then H+1 records of {HI, LO}, then C.
//   instruction = {HI[5:0], LO[7:0]}; HI[7:6] must be 2'b00.
//   (H + sum(HI) + sum(LO) + C) mod 256 must be 0.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   i_start             one-cycle request to begin a session (IDLE/DONE/ERROR)
//   i_byte_valid        i_byte carries a byte this cycle
//   i_byte[7:0]         stream byte
//   o_byte_ready        loader accepts a byte this cycle (state-only)
//   o_load_enable       one-cycle program-memory write strobe
//   o_load_address[7:0] program-memory write address
//   o_load_instruction[13:0] program-memory write data
//   o_busy              load in progress / CPU hold
//   o_done              last load finished with a good checksum (sticky)
//   o_error             last load aborted on format/checksum error (sticky)
// -----------------------------------------------------------------------------
module program_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_load_enable,
  output logic [7:0]  o_load_address,
  output logic [13:0] o_load_instruction,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           word_cnt_q, word_cnt_d;   // words remaining after the current one
  logic [ADDR_W-1:0]    addr_q, addr_d;           // address of the word being assembled
  logic [7:0]           acc_q, acc_d;             // running checksum, wraps mod 256
  logic [5:0]           hi_q, hi_d;               // payload bits of the latched HI byte
  logic                 load_en_q, load_en_d;
  logic [ADDR_W-1:0]    load_addr_q, load_addr_d;
  logic [INSTR_W-1:0]   load_instr_q, load_instr_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 in_session;
  logic                 accept;
  logic [7:0]           acc_plus_byte;

  // Ready and busy depend on the registered state alone, so a valid gap
  // cannot ripple combinationally back into the handshake.
  assign in_session    = (state_q == ST_HDR) || (state_q == ST_HI) ||
                         (state_q == ST_LO)  || (state_q == ST_CHK);
  assign accept        = i_byte_valid && in_session;
  assign acc_plus_byte = acc_q + i_byte;

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    hi_d         = hi_q;
    load_en_d    = 1'b0;
    load_addr_d  = load_addr_q;
    load_instr_d = load_instr_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          acc_d   = '0;
        end
      end

      ST_HDR: begin
        if (accept) begin
          word_cnt_d = i_byte;
          acc_d      = i_byte;
          state_d    = ST_HI;
        end
      end

      ST_HI: begin
        if (accept) begin
          acc_d = acc_plus_byte;
          if (i_byte[7:6] != 2'b00) begin
            // Malformed record: abort before any write is issued for it.
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            hi_d    = i_byte[5:0];
            state_d = ST_LO;
          end
        end
      end

      ST_LO: begin
        if (accept) begin
          acc_d        = acc_plus_byte;
          load_en_d    = 1'b1;
          load_addr_d  = addr_q;
          load_instr_d = {hi_q, i_byte};
          if (word_cnt_q == 8'd0) begin
            // Last word: the address is left alone so a 256-word load
            // never wraps past 255.
            state_d = ST_CHK;
          end else begin
            word_cnt_d = word_cnt_q - 8'd1;
            addr_d     = addr_q + 8'd1;
            state_d    = ST_HI;
          end
        end
      end

      ST_CHK: begin
        if (accept) begin
          if (acc_plus_byte == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      hi_q         <= '0;
      load_en_q    <= 1'b0;
      load_addr_q  <= '0;
      load_instr_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      hi_q         <= hi_d;
      load_en_q    <= load_en_d;
      load_addr_q  <= load_addr_d;
      load_instr_q <= load_instr_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign o_byte_ready       = in_session;
  assign o_busy             = in_session;
  assign o_load_enable      = load_en_q;
  assign o_load_address     = load_addr_q;
  assign o_load_instruction = load_instr_q;
  assign o_done             = done_q;
  assign o_error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Bytes are driven on the falling edge and
// outputs are sampled on the falling edge. A monitor logs every write strobe,
// in order, #1 after the rising edge. Expected values are hand-computed or
// derived from the stream contents by the bench.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_load_enable;
  logic [7:0]  o_load_address;
  logic [13:0] o_load_instruction;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  int n_total = 0;
  int n_bad   = 0;

  // Write log and a shadow of program memory
  logic [7:0]  wr_addr [0:1023];
  logic [13:0] wr_data [0:1023];
  logic [13:0] mem     [0:255];
  int          wr_cnt = 0;

  program_loader dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_byte_valid       (i_byte_valid),
    .i_byte             (i_byte),
    .o_byte_ready       (o_byte_ready),
    .o_load_enable      (o_load_enable),
    .o_load_address     (o_load_address),
    .o_load_instruction (o_load_instruction),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_error            (o_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_load_enable) begin
      wr_addr[wr_cnt]      = o_load_address;
      wr_data[wr_cnt]      = o_load_instruction;
      mem[o_load_address]  = o_load_instruction;
      wr_cnt               = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse i_start for one cycle; returns on the falling edge after it.
  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Drive one byte after `gap` idle cycles. Returns on the falling edge
  // following the transfer edge, so registered results are visible.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    i_byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      i_byte = 8'hxx;
      @(negedge clk);
    end
    i_byte_valid = 1'b1;
    i_byte       = b;
    waited       = 0;
    while (!o_byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!o_byte_ready) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  // Basic two-word stream: 01, 12 34, 05 67, C.
  // Sum = 01+12+34+05+67 = 0xB3, so the good checksum is 0x4D.
  task automatic basic_stream(input string tag, input logic [7:0] c, input int max_gap);
    send_byte(8'h01, $urandom_range(max_gap, 0));
    send_byte(8'h12, $urandom_range(max_gap, 0));
    send_byte(8'h34, $urandom_range(max_gap, 0));
    send_byte(8'h05, $urandom_range(max_gap, 0));
    send_byte(8'h67, $urandom_range(max_gap, 0));
    send_byte(c,     $urandom_range(max_gap, 0));
  endtask

  task automatic check_basic_writes(input string tag, input int base);
    check({tag, "_wcnt"},  wr_cnt - base, 2);
    check({tag, "_a0"},    {24'd0, wr_addr[base]},     0);
    check({tag, "_d0"},    {18'd0, wr_data[base]},     32'h1234);
    check({tag, "_a1"},    {24'd0, wr_addr[base + 1]}, 1);
    check({tag, "_d1"},    {18'd0, wr_data[base + 1]}, 32'h0567);
  endtask

  initial begin
    int base;
    logic [7:0] sum;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    repeat (3) @(negedge clk);

    // ---- Reset values
    check("rst_ready", o_byte_ready, 0);
    check("rst_we",    o_load_enable, 0);
    check("rst_addr",  o_load_address, 0);
    check("rst_instr", o_load_instruction, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_done",  o_done, 0);
    check("rst_error", o_error, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- Basic load with cycle-level timing
    pulse_start();
    check("basic_busy_rise", o_busy, 1);
    check("basic_ready_hdr", o_byte_ready, 1);
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    check("basic_no_we_hi", o_load_enable, 0);
    send_byte(8'h34, 0);
    check("basic_we0",      o_load_enable, 1);
    check("basic_we0_addr", o_load_address, 8'h00);
    check("basic_we0_data", o_load_instruction, 14'h1234);
    send_byte(8'h05, 0);
    check("basic_we_pulse", o_load_enable, 0);
    send_byte(8'h67, 0);
    check("basic_we1_chk",  o_load_enable, 1);
    check("basic_we1_addr", o_load_address, 8'h01);
    check("basic_we1_data", o_load_instruction, 14'h0567);
    check("basic_chk_busy", o_busy, 1);
    send_byte(8'h4D, 0);
    check("basic_done",  o_done, 1);
    check("basic_error", o_error, 0);
    check("basic_busy",  o_busy, 0);
    check("basic_ready", o_byte_ready, 0);
    check_basic_writes("basic", base);
    repeat (2) @(negedge clk);
    check("basic_done_sticky", o_done, 1);

    // ---- Checksum error
    pulse_start();
    check("ck_done_cleared", o_done, 0);
    base = wr_cnt;
    basic_stream("ck", 8'h48, 0);
    check("ck_error", o_error, 1);
    check("ck_done",  o_done, 0);
    check("ck_busy",  o_busy, 0);
    check_basic_writes("ck", base);

    // ---- Format error: HI = 0x40
    pulse_start();
    check("fmt_error_cleared", o_error, 0);
    base = wr_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    check("fmt_error", o_error, 1);
    check("fmt_done",  o_done, 0);
    check("fmt_ready", o_byte_ready, 0);
    check("fmt_busy",  o_busy, 0);
    @(negedge clk);
    check("fmt_no_write", wr_cnt - base, 0);

    // ---- Full memory: 256 words, value = address
    pulse_start();
    base = wr_cnt;
    sum  = 8'hFF;
    send_byte(8'hFF, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 0);
      send_byte(i[7:0], 0);
      sum = sum + i[7:0];
    end
    // sum of 0..255 = 0x7F80 -> 0x80, plus 0xFF -> 0x7F, C = 0x81
    check("full_csum_calc", {24'd0, 8'h00 - sum}, 32'h81);
    send_byte(8'h00 - sum, 0);
    check("full_done",  o_done, 1);
    check("full_error", o_error, 0);
    check("full_wcnt",  wr_cnt - base, 256);
    for (int i = 0; i < 256; i++) begin
      check("full_addr", {24'd0, wr_addr[base + i]}, i);
      check("full_data", {18'd0, wr_data[base + i]}, i);
    end

    // ---- Handshake stalls: random gaps between every byte
    pulse_start();
    base = wr_cnt;
    send_byte(8'h01, 2);
    check("gap_ready_held", o_byte_ready, 1);
    send_byte(8'h12, $urandom_range(3, 1));
    send_byte(8'h34, $urandom_range(3, 1));
    send_byte(8'h05, $urandom_range(3, 1));
    send_byte(8'h67, $urandom_range(3, 1));
    repeat (3) @(negedge clk);
    check("gap_still_chk", o_busy, 1);
    send_byte(8'h4D, $urandom_range(3, 1));
    check("gap_done",  o_done, 1);
    check("gap_error", o_error, 0);
    check_basic_writes("gap", base);

    // ---- i_start while busy is ignored
    pulse_start();
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    pulse_start();
    check("ign_busy", o_busy, 1);
    send_byte(8'h34, 0);
    send_byte(8'h05, 0);
    pulse_start();
    send_byte(8'h67, 0);
    send_byte(8'h4D, 0);
    check("ign_done", o_done, 1);
    check_basic_writes("ign", base);

    // ---- Reset mid-load after first word of a 3-word load
    mem[0] = 14'h0000;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h2A, 0);
    send_byte(8'hBC, 0);
    send_byte(8'h01, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",  o_busy, 0);
    check("mrst_ready", o_byte_ready, 0);
    check("mrst_we",    o_load_enable, 0);
    check("mrst_addr",  o_load_address, 0);
    check("mrst_instr", o_load_instruction, 0);
    check("mrst_done",  o_done, 0);
    check("mrst_error", o_error, 0);
    check("mrst_word0", mem[0], 14'h2ABC);
    @(negedge clk);
    check("mrst_idle", o_busy, 0);
    pulse_start();
    check("mrst_restart", o_busy, 1);
    base = wr_cnt;
    basic_stream("rec", 8'h4D, 1);
    check("rec_done", o_done, 1);
    check_basic_writes("rec", base);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
